// File: rtl/gate_identifier.sv
// Gate identifier: walks an unknown 2-input gate through the input vectors
// 00, 01, 10 and 11, in that order. Each vector is held for SETTLE_CYCLES clocks.
// The gate's response is captured on the last edge of each vector.
// The captured 4-entry truth table is then classified as one of the known gate types.
module gate_identifier #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_gate_out,
  output logic       o_in1,
  output logic       o_in2,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_truth,
  output logic [2:0] o_code
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_vec;
  logic [CNT_W-1:0] r_cnt;
  // Shadow entries for vectors 0..2; the vector-3 sample goes straight into the result.
  logic [2:0]       r_tt;
  logic             r_busy;
  logic             r_done;
  logic [3:0]       r_truth;
  logic [2:0]       r_code;
  logic [3:0]       w_final_tt;

  // Exact-match classification; anything else (constants, NOT(in2), ...) is UNKNOWN.
  function automatic logic [2:0] classify(input logic [3:0] tt);
    logic [2:0] code;
    case (tt)
      4'b0011: code = 3'd1;  // NOT(in1)
      4'b1110: code = 3'd2;  // OR
      4'b1000: code = 3'd3;  // AND
      4'b0001: code = 3'd4;  // NOR
      4'b0111: code = 3'd5;  // NAND
      4'b0110: code = 3'd6;  // XOR
      4'b1001: code = 3'd7;  // XNOR
      default: code = 3'd0;  // UNKNOWN
    endcase
    return code;
  endfunction

  // The full table on the completion edge includes the sample that is being taken now.
  assign w_final_tt = {i_gate_out, r_tt};

  // Sequencer: holds each vector, samples the gate at the vector end, and publishes the result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_vec   <= 2'd0;
      r_cnt   <= '0;
      r_tt    <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_truth <= 4'd0;
      r_code  <= 3'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_vec   <= 2'd0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            // Abandon the run; the previously published result stays visible.
            r_state <= ST_IDLE;
            r_vec   <= 2'd0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_vec != 2'd3) begin
              for (int i = 0; i < 3; i++) begin
                if (r_vec == 2'(i)) r_tt[i] <= i_gate_out;
              end
              r_vec <= r_vec + 2'd1;
            end else begin
              r_state <= ST_IDLE;
              r_vec   <= 2'd0;
              r_busy  <= 1'b0;
              r_truth <= w_final_tt;
              r_code  <= classify(w_final_tt);
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in1   = r_vec[1];
  assign o_in2   = r_vec[0];
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_truth = r_truth;
  assign o_code  = r_code;

endmodule

// File: tb/tb_gate_identifier.sv
// Bench for gate_identifier. Instance A uses SETTLE_CYCLES=2 and instance B uses SETTLE_CYCLES=1.
// Expected results are queued when a run is started.
// Per-instance monitors pop those results and compare them whenever o_done is seen.
module tb_gate_identifier;

  typedef struct {
    logic [3:0] truth;
    logic [2:0] code;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Instance A signals
  logic st_a = 1'b0, ab_a = 1'b0, g_a;
  logic a_in1, a_in2, a_busy, a_done;
  logic [3:0] a_truth, mtt_a = 4'b0000;
  logic [2:0] a_code;
  exp_t qa[$];

  // Instance B signals
  logic st_b = 1'b0, ab_b = 1'b0, g_b = 1'b0;
  logic b_in1, b_in2, b_busy, b_done;
  logic [3:0] b_truth, mtt_b = 4'b0000;
  logic [2:0] b_code;
  exp_t qb[$];

  gate_identifier #(.SETTLE_CYCLES(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st_a), .i_abort(ab_a), .i_gate_out(g_a),
    .o_in1(a_in1), .o_in2(a_in2), .o_busy(a_busy), .o_done(a_done),
    .o_truth(a_truth), .o_code(a_code)
  );

  gate_identifier #(.SETTLE_CYCLES(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st_b), .i_abort(ab_b), .i_gate_out(g_b),
    .o_in1(b_in1), .o_in2(b_in2), .o_busy(b_busy), .o_done(b_done),
    .o_truth(b_truth), .o_code(b_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate A is a clean combinational model of the selected truth table.
  assign g_a = mtt_a[{a_in1, a_in2}];

  // Gate B glitches to the wrong value between edges and settles before each rising edge.
  always @(posedge clk) begin
    #3 g_b = ~mtt_b[{b_in1, b_in2}];
  end
  always @(negedge clk) g_b = mtt_b[{b_in1, b_in2}];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor A: every o_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && a_done) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_truth", int'(a_truth), int'(e.truth));
        chk("a_code", int'(a_code), int'(e.code));
        chk("a_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (rst_n && b_done) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_truth", int'(b_truth), int'(e.truth));
        chk("b_code", int'(b_code), int'(e.code));
        chk("b_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Pulse start on A for one edge and queue the expected outcome.
  task automatic start_a(input logic [3:0] tt, input logic [2:0] code);
    @(posedge clk); #1;
    mtt_a = tt;
    st_a = 1'b1;
    qa.push_back('{truth: tt, code: code, cyc: cyc + 1 + 8});
    @(posedge clk); #1;
    st_a = 1'b0;
  endtask

  task automatic start_b(input logic [3:0] tt, input logic [2:0] code, input logic with_abort);
    @(posedge clk); #1;
    mtt_b = tt;
    st_b = 1'b1;
    ab_b = with_abort;
    qb.push_back('{truth: tt, code: code, cyc: cyc + 1 + 4});
    @(posedge clk); #1;
    st_b = 1'b0;
    ab_b = 1'b0;
  endtask

  task automatic wait_done_a(input int max);
    int n = 0;
    while (!a_done && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!a_done) chk("a_done_timeout", 0, 1);
  endtask

  task automatic wait_done_b(input int max);
    int n = 0;
    while (!b_done && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!b_done) chk("b_done_timeout", 0, 1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_a_outs", int'({a_in1, a_in2, a_busy, a_done}), 0);
    chk("rst_a_truth", int'(a_truth), 0);
    chk("rst_a_code", int'(a_code), 0);
    chk("rst_b_outs", int'({b_in1, b_in2, b_busy, b_done, b_truth, b_code}), 0);
    @(negedge clk); rst_n = 1'b1;

    // Test 1: AND gate; inputs step 00,01,10,11 with two clocks per vector
    start_a(4'b1000, 3'd3);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_vec", int'({a_in1, a_in2}), k / 2);
      chk("t1_busy", int'(a_busy), 1);
      @(posedge clk);
    end
    wait_done_a(4);
    chk("t1_in_idle", int'({a_in1, a_in2, a_busy}), 0);

    // Test 2: XOR then XNOR back-to-back, with start held high through the done cycle
    @(posedge clk); #1;
    mtt_a = 4'b0110;
    st_a = 1'b1;
    qa.push_back('{truth: 4'b0110, code: 3'd6, cyc: cyc + 1 + 8});
    qa.push_back('{truth: 4'b1001, code: 3'd7, cyc: cyc + 1 + 17});
    wait_done_a(20);
    mtt_a = 4'b1001;
    @(posedge clk); #1;
    st_a = 1'b0;
    @(negedge clk);
    chk("t2_no_gap_busy", int'(a_busy), 1);
    wait_done_a(20);

    // Test 3: constant 1 is UNKNOWN; ~in1 is NOT
    start_a(4'b1111, 3'd0);
    wait_done_a(20);
    start_a(4'b0011, 3'd1);
    wait_done_a(20);

    // Test 4: abort during vector 2 after an AND result
    start_a(4'b1000, 3'd3);
    wait_done_a(20);
    @(posedge clk); #1;
    mtt_a = 4'b0110;
    st_a = 1'b1;
    @(posedge clk); #1;   // E0
    st_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_in_vec2", int'({a_in1, a_in2}), 2);
    ab_a = 1'b1;
    @(posedge clk); #1;
    ab_a = 1'b0;
    chk("t4_busy_drop", int'(a_busy), 0);
    chk("t4_inputs", int'({a_in1, a_in2}), 0);
    chk("t4_truth_kept", int'(a_truth), 4'b1000);
    chk("t4_code_kept", int'(a_code), 3);
    repeat (12) @(negedge clk);
    chk("t4_no_done_q", qa.size(), 0);

    // Test 5: asynchronous reset mid-run, then a normal NAND run
    start_a(4'b1110, 3'd2);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", int'({a_in1, a_in2, a_busy, a_done}), 0);
    chk("t5_rst_truth", int'(a_truth), 0);
    chk("t5_rst_code", int'(a_code), 0);
    qa.delete();
    @(negedge clk); rst_n = 1'b1;
    start_a(4'b0111, 3'd5);
    wait_done_a(20);

    // Test 6: SETTLE=1 with a gate that glitches between edges
    start_b(4'b0001, 3'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_vec", int'({b_in1, b_in2}), k);
      if (k < 3) @(posedge clk);
    end
    wait_done_b(6);
    // Start and abort together while idle: the start is taken
    start_b(4'b1001, 3'd7, 1'b1);
    wait_done_b(8);

    repeat (6) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "time limit");
  end

endmodule
